// File: rtl/wb_merge_arb.sv
// Write-back merger: one FIFO per functional unit, round-robin selection of
// the FIFO heads, and a single registered write-back port toward the bypass
// buffer / register file. A downstream stall freezes every pop and the
// round-robin pointer while pushes continue to be accepted.
module wb_merge_arb #(
  parameter int NUM_SRC    = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int IDX_W      = 8,
  parameter int DATA_W     = 32,
  localparam int SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      I_Stall,
  input  logic [NUM_SRC-1:0]        I_Valid,
  input  logic [NUM_SRC*IDX_W-1:0]  I_Index,
  input  logic [NUM_SRC*DATA_W-1:0] I_Data,
  output logic [NUM_SRC-1:0]        O_Ready,
  output logic                      O_WB_Valid,
  output logic [IDX_W-1:0]          O_WB_Index,
  output logic [DATA_W-1:0]         O_WB_Data,
  output logic [SRC_W-1:0]          O_WB_Src,
  output logic                      O_Pending,
  output logic                      O_Overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = IDX_W + DATA_W;

  logic [NUM_SRC-1:0]       req_p0;
  logic [NUM_SRC-1:0]       push_p0;
  logic [NUM_SRC-1:0]       pop_sel_p0;
  logic [NUM_SRC*ENT_W-1:0] head_flat_p0;
  logic [SRC_W-1:0]         rr_ptr;
  logic                     grant_vld_p0;
  logic [SRC_W-1:0]         grant_src_p0;
  logic [ENT_W-1:0]         grant_ent_p0;
  logic                     pop_p0;

  // ---- stage p0: per-unit FIFOs (write at tail, head visible next cycle) ----
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fifo
    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    // Ready comes from the registered count only, so a full FIFO stays
    // not-ready even in a cycle where its head is being popped.
    assign O_Ready[g]  = (count != CNT_W'(FIFO_DEPTH));
    assign req_p0[g]   = (count != '0);
    assign push_p0[g]  = I_Valid[g] & O_Ready[g];
    assign head_flat_p0[g*ENT_W +: ENT_W] = mem[rd_ptr];

    // Entry storage: data only, never reset.
    always_ff @(posedge clock) begin
      if (push_p0[g]) begin
        mem[wr_ptr] <= {I_Index[g*IDX_W +: IDX_W], I_Data[g*DATA_W +: DATA_W]};
      end
    end

    // Pointer/count bookkeeping; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clock) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_p0[g]) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop_sel_p0[g]) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        if (push_p0[g] && !pop_sel_p0[g]) begin
          count <= count + CNT_W'(1);
        end else if (!push_p0[g] && pop_sel_p0[g]) begin
          count <= count - CNT_W'(1);
        end
      end
    end
  end

  // Round-robin search over non-empty FIFOs, starting just after rr_ptr.
  always_comb begin
    int cand;
    grant_vld_p0 = 1'b0;
    grant_src_p0 = '0;
    grant_ent_p0 = '0;
    cand         = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_SRC;
      if (!grant_vld_p0 && req_p0[cand]) begin
        grant_vld_p0 = 1'b1;
        grant_src_p0 = SRC_W'(cand);
        grant_ent_p0 = head_flat_p0[cand*ENT_W +: ENT_W];
      end
    end
  end

  assign pop_p0     = grant_vld_p0 & ~I_Stall;
  assign pop_sel_p0 = pop_p0 ? (NUM_SRC'(1) << grant_src_p0) : '0;

  // Round-robin pointer follows the last popped unit; frozen under stall.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= SRC_W'(NUM_SRC - 1);
    end else if (pop_p0) begin
      rr_ptr <= grant_src_p0;
    end
  end

  // Sticky overflow: any push attempt into a full FIFO.
  always_ff @(posedge clock) begin
    if (reset) begin
      O_Overflow <= 1'b0;
    end else if (|(I_Valid & ~O_Ready)) begin
      O_Overflow <= 1'b1;
    end
  end

  // ---- stage p1: registered write-back port (payload holds when idle) ----
  always_ff @(posedge clock) begin
    if (reset) begin
      O_WB_Valid <= 1'b0;
      O_WB_Index <= '0;
      O_WB_Data  <= '0;
      O_WB_Src   <= '0;
    end else begin
      O_WB_Valid <= pop_p0;
      if (pop_p0) begin
        O_WB_Index <= grant_ent_p0[ENT_W-1:DATA_W];
        O_WB_Data  <= grant_ent_p0[DATA_W-1:0];
        O_WB_Src   <= grant_src_p0;
      end
    end
  end

  assign O_Pending = (|req_p0) | O_WB_Valid;

endmodule

// File: tb/tb_wb_merge_arb.sv
// Bench for wb_merge_arb: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_wb_merge_arb;

  localparam int NS = 3;
  localparam int D  = 4;
  localparam int IW = 8;
  localparam int DW = 32;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           stall = 1'b0;
  logic [NS-1:0]  vld = '0;
  logic [NS*IW-1:0] idx_bus = '0;
  logic [NS*DW-1:0] dat_bus = '0;
  logic [NS-1:0]  o_ready;
  logic           o_wb_valid;
  logic [IW-1:0]  o_wb_index;
  logic [DW-1:0]  o_wb_data;
  logic [1:0]     o_wb_src;
  logic           o_pending;
  logic           o_overflow;

  int tests = 0;
  int fails = 0;

  wb_merge_arb #(.NUM_SRC(NS), .FIFO_DEPTH(D), .IDX_W(IW), .DATA_W(DW)) dut (
    .clock      (clock),
    .reset      (reset),
    .I_Stall    (stall),
    .I_Valid    (vld),
    .I_Index    (idx_bus),
    .I_Data     (dat_bus),
    .O_Ready    (o_ready),
    .O_WB_Valid (o_wb_valid),
    .O_WB_Index (o_wb_index),
    .O_WB_Data  (o_wb_data),
    .O_WB_Src   (o_wb_src),
    .O_Pending  (o_pending),
    .O_Overflow (o_overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one queue per unit, round-robin over non-empty queues.
  logic [IW+DW-1:0] mq [NS][$];
  int               m_rr    = NS - 1;
  logic             m_valid = 1'b0;
  logic [IW-1:0]    m_idx   = '0;
  logic [DW-1:0]    m_data  = '0;
  int               m_src   = 0;
  logic             m_ovf   = 1'b0;

  always @(posedge clock) begin
    bit rdy [NS];
    int g;
    int c;
    logic [IW+DW-1:0] e;
    if (reset) begin
      for (int i = 0; i < NS; i++) mq[i].delete();
      m_rr = NS - 1; m_valid = 0; m_idx = 0; m_data = 0; m_src = 0; m_ovf = 0;
    end else begin
      for (int i = 0; i < NS; i++) rdy[i] = (mq[i].size() != D);
      g = -1;
      for (int k = 1; k <= NS; k++) begin
        c = (m_rr + k) % NS;
        if (g < 0 && mq[c].size() > 0) g = c;
      end
      if (g >= 0 && !stall) begin
        e = mq[g].pop_front();
        m_valid = 1; m_idx = e[IW+DW-1:DW]; m_data = e[DW-1:0]; m_src = g; m_rr = g;
      end else begin
        m_valid = 0;
      end
      for (int i = 0; i < NS; i++) begin
        if (vld[i]) begin
          if (rdy[i]) mq[i].push_back({idx_bus[i*IW +: IW], dat_bus[i*DW +: DW]});
          else m_ovf = 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    logic [NS-1:0] er;
    bit any;
    any = m_valid;
    for (int i = 0; i < NS; i++) begin
      er[i] = (mq[i].size() != D);
      if (mq[i].size() > 0) any = 1;
    end
    check("m_wb_valid", 64'(o_wb_valid), 64'(m_valid));
    check("m_wb_index", 64'(o_wb_index), 64'(m_idx));
    check("m_wb_data",  64'(o_wb_data),  64'(m_data));
    check("m_wb_src",   64'(o_wb_src),   64'(m_src));
    check("m_ready",    64'(o_ready),    64'(er));
    check("m_pending",  64'(o_pending),  64'(any));
    check("m_overflow", 64'(o_overflow), 64'(m_ovf));
  end

  // Write-back log {src, index, data} captured from the DUT.
  logic [2+IW+DW-1:0] wb_log [$];
  always @(negedge clock) begin
    if (o_wb_valid === 1'b1) wb_log.push_back({o_wb_src, o_wb_index, o_wb_data});
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_unit(input int u, input int tag);
    idx_bus[u*IW +: IW] = IW'(16 * u + tag);
    dat_bus[u*DW +: DW] = DW'((u << 24) | tag);
  endtask

  task automatic reset_dut();
    vld = '0; stall = 1'b0; reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  // Check log holds n entries, src k%period+base order, data tag from k.
  task automatic check_rr_log(input string nm, input int n);
    check({nm, "_count"}, 64'(wb_log.size()), 64'(n));
    for (int k = 0; k < n && k < wb_log.size(); k++) begin
      check({nm, "_src"},  64'(wb_log[k][IW+DW +: 2]), 64'(k % NS));
      check({nm, "_data"}, 64'(wb_log[k][DW-1:0]), 64'(((k % NS) << 24) | (k / NS)));
    end
  endtask

  initial begin
    // Reset state
    cyc(); cyc();
    check("rst_valid",    64'(o_wb_valid), 64'(0));
    check("rst_ready",    64'(o_ready),    64'(3'b111));
    check("rst_pending",  64'(o_pending),  64'(0));
    check("rst_overflow", 64'(o_overflow), 64'(0));
    check("rst_data",     64'(o_wb_data),  64'(0));
    reset = 1'b0;

    // Single push on unit 1: visible two edges later for one cycle
    vld = 3'b010; idx_bus[IW +: IW] = 8'd5; dat_bus[DW +: DW] = 32'hDEADBEEF;
    cyc();
    vld = '0;
    check("t1_lat1_valid", 64'(o_wb_valid), 64'(0));
    check("t1_lat1_pend",  64'(o_pending),  64'(1));
    cyc();
    check("t1_valid", 64'(o_wb_valid), 64'(1));
    check("t1_index", 64'(o_wb_index), 64'(5));
    check("t1_data",  64'(o_wb_data),  64'h0000_0000_DEAD_BEEF);
    check("t1_src",   64'(o_wb_src),   64'(1));
    cyc();
    check("t1_pulse_end", 64'(o_wb_valid), 64'(0));
    check("t1_hold_data", 64'(o_wb_data),  64'h0000_0000_DEAD_BEEF);

    // All units push for 4 cycles: 0,1,2,0,1,2,... back to back
    reset_dut(); wb_log.delete();
    for (int c = 0; c < 4; c++) begin
      vld = 3'b111;
      for (int u = 0; u < NS; u++) set_unit(u, c);
      cyc();
    end
    vld = '0;
    repeat (14) cyc();
    check_rr_log("t2", 12);

    // Overflow on unit 0 under stall, then in-order drain
    reset_dut(); wb_log.delete(); stall = 1'b1;
    for (int c = 0; c < 4; c++) begin
      vld = 3'b001; set_unit(0, c); cyc();
    end
    check("t3_ready_full", 64'(o_ready[0]), 64'(0));
    check("t3_ovf_before", 64'(o_overflow), 64'(0));
    set_unit(0, 4); cyc();
    vld = '0;
    check("t3_ovf_set", 64'(o_overflow), 64'(1));
    repeat (2) cyc();
    check("t3_stall_valid", 64'(o_wb_valid), 64'(0));
    stall = 1'b0;
    repeat (6) cyc();
    check("t3_count", 64'(wb_log.size()), 64'(4));
    for (int k = 0; k < 4 && k < wb_log.size(); k++)
      check("t3_data", 64'(wb_log[k][DW-1:0]), 64'(k));
    check("t3_ovf_sticky", 64'(o_overflow), 64'(1));

    // Stall for 3 cycles mid-stream: no loss, no duplicate, RR resumes
    reset_dut(); wb_log.delete();
    for (int c = 0; c < 4; c++) begin
      vld = 3'b111;
      for (int u = 0; u < NS; u++) set_unit(u, c);
      if (c == 2) stall = 1'b1;
      cyc();
    end
    vld = '0;
    check("t4_stall_valid", 64'(o_wb_valid), 64'(0));
    cyc();
    stall = 1'b0;
    repeat (14) cyc();
    check_rr_log("t4", 12);

    // Unit 2: fill, then push+pop each cycle across pointer wrap
    reset_dut(); wb_log.delete(); stall = 1'b1;
    for (int c = 0; c < 4; c++) begin
      vld = 3'b100; set_unit(2, c); cyc();
    end
    vld = '0;
    check("t5_full", 64'(o_ready[2]), 64'(0));
    stall = 1'b0;
    cyc();
    check("t5_ready_again", 64'(o_ready[2]), 64'(1));
    for (int c = 4; c < 12; c++) begin
      vld = 3'b100; set_unit(2, c); cyc();
    end
    vld = '0;
    repeat (6) cyc();
    check("t5_count", 64'(wb_log.size()), 64'(12));
    for (int k = 0; k < 12 && k < wb_log.size(); k++) begin
      check("t5_src",  64'(wb_log[k][IW+DW +: 2]), 64'(2));
      check("t5_data", 64'(wb_log[k][DW-1:0]), 64'((2 << 24) | k));
    end
    check("t5_no_ovf", 64'(o_overflow), 64'(0));

    // Reset with 5 entries queued discards them silently
    reset_dut(); stall = 1'b1;
    vld = 3'b011; set_unit(0, 0); set_unit(1, 0); cyc();
    set_unit(0, 1); set_unit(1, 1); cyc();
    vld = 3'b001; set_unit(0, 2); cyc();
    vld = '0;
    check("t6_pending_before", 64'(o_pending), 64'(1));
    reset = 1'b1;
    cyc();
    check("t6_pending", 64'(o_pending),  64'(0));
    check("t6_ready",   64'(o_ready),    64'(3'b111));
    check("t6_valid",   64'(o_wb_valid), 64'(0));
    reset = 1'b0; stall = 1'b0; wb_log.delete();
    repeat (4) cyc();
    check("t6_no_pulse", 64'(wb_log.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
